// File: rtl/fb_write_sched.sv
// fb_write_sched: sole owner of the frame-buffer RAM write port.
// Runs a full-frame clear after reset or on request. Between clears it
// round-robin arbitrates the brush painter and the aux requester. Each
// accepted in-range request becomes one registered RAM write on the
// following cycle. Requests outside the frame are consumed, not written,
// and latch a sticky error flag.
module fb_write_sched #(
  parameter int                ADDR_W         = 20,
  parameter int                DATA_W         = 9,
  parameter int                NUM_PIXELS     = 307200,
  parameter logic [DATA_W-1:0] CLEAR_COLOR    = DATA_W'(9'h1FF),
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  input  logic              paint_valid,
  output logic              paint_ready,
  input  logic [ADDR_W-1:0] paint_addr,
  input  logic [DATA_W-1:0] paint_data,
  input  logic              aux_valid,
  output logic              aux_ready,
  input  logic [ADDR_W-1:0] aux_addr,
  input  logic [DATA_W-1:0] aux_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              oob_err
);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_SERVE = 1'b1
  } state_t;

  // One extra bit so the frame size itself is representable when
  // NUM_PIXELS equals 2**ADDR_W.
  localparam logic [ADDR_W:0]   LP_NUM  = (ADDR_W+1)'(NUM_PIXELS);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_PIXELS - 1);
  localparam state_t            LP_RST_STATE = CLEAR_ON_RESET ? S_CLEAR : S_SERVE;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_last;      // final clear write is on the bus
  logic                r_prio_aux;  // 1: aux wins the next contested cycle
  logic                r_mem_we_p1;
  logic [ADDR_W-1:0]   r_mem_addr_p1;
  logic [DATA_W-1:0]   r_mem_data_p1;
  logic                r_busy;
  logic                r_done;
  logic                r_oob;

  logic                w_serve;
  logic                w_grant_p;
  logic                w_grant_a;
  logic                w_grant;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_in_range;

  // Unsigned test against the frame size.
  function automatic logic in_frame(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < LP_NUM);
  endfunction

  // Stage p0: combinational arbitration; a clear request blocks all grants.
  assign w_serve    = (r_state == S_SERVE) && !clear_req;
  assign w_grant_p  = w_serve && paint_valid && (!aux_valid || !r_prio_aux);
  assign w_grant_a  = w_serve && aux_valid && (!paint_valid || r_prio_aux);
  assign w_grant    = w_grant_p || w_grant_a;
  assign w_sel_addr = w_grant_a ? aux_addr : paint_addr;
  assign w_sel_data = w_grant_a ? aux_data : paint_data;
  assign w_in_range = in_frame(w_sel_addr);

  assign paint_ready = w_grant_p;
  assign aux_ready   = w_grant_a;

  // Control FSM: clear sequencing, grant capture into the write register, sticky error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= LP_RST_STATE;
      r_cnt         <= '0;
      r_last        <= 1'b0;
      r_prio_aux    <= 1'b0;
      r_mem_we_p1   <= 1'b0;
      r_mem_addr_p1 <= '0;
      r_mem_data_p1 <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_oob         <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_CLEAR: begin
          if (r_last) begin
            // Last clear write already issued: hand the port back.
            r_state     <= S_SERVE;
            r_last      <= 1'b0;
            r_mem_we_p1 <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_cnt       <= '0;
          end else begin
            r_mem_we_p1   <= 1'b1;
            r_mem_addr_p1 <= r_cnt;
            r_mem_data_p1 <= CLEAR_COLOR;
            r_busy        <= 1'b1;
            if (r_cnt == LP_LAST) begin
              r_last <= 1'b1;
              r_cnt  <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_SERVE: begin
          if (clear_req) begin
            r_state     <= S_CLEAR;
            r_mem_we_p1 <= 1'b0;
            r_busy      <= 1'b1;
            r_cnt       <= '0;
            r_last      <= 1'b0;
          end else begin
            // Stage p1: registered write of the granted request.
            r_mem_we_p1 <= w_grant && w_in_range;
            if (w_grant && w_in_range) begin
              r_mem_addr_p1 <= w_sel_addr;
              r_mem_data_p1 <= w_sel_data;
            end
            if (w_grant) begin
              r_prio_aux <= w_grant_p;
              if (!w_in_range) begin
                r_oob <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state <= S_SERVE;
        end
      endcase
    end
  end

  assign mem_we     = r_mem_we_p1;
  assign mem_addr   = r_mem_addr_p1;
  assign mem_data   = r_mem_data_p1;
  assign clear_busy = r_busy;
  assign clear_done = r_done;
  assign oob_err    = r_oob;

endmodule

// File: tb/tb_fb_write_sched.sv
// Bench for fb_write_sched with a 16-pixel frame: directed scenarios plus
// randomized traffic, all compared every cycle against a behavioural model.
module tb_fb_write_sched;

  localparam int          AW = 20;
  localparam int          DW = 9;
  localparam int          NP = 16;
  localparam logic [8:0]  CC = 9'h1FF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clear_req = 1'b0;
  logic          clear_busy, clear_done;
  logic          paint_valid = 1'b0;
  logic          paint_ready;
  logic [AW-1:0] paint_addr = '0;
  logic [DW-1:0] paint_data = '0;
  logic          aux_valid = 1'b0;
  logic          aux_ready;
  logic [AW-1:0] aux_addr = '0;
  logic [DW-1:0] aux_data = '0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          oob_err;

  fb_write_sched #(
    .ADDR_W(AW), .DATA_W(DW), .NUM_PIXELS(NP),
    .CLEAR_COLOR(CC), .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .clear_busy(clear_busy), .clear_done(clear_done),
    .paint_valid(paint_valid), .paint_ready(paint_ready),
    .paint_addr(paint_addr), .paint_data(paint_data),
    .aux_valid(aux_valid), .aux_ready(aux_ready),
    .aux_addr(aux_addr), .aux_data(aux_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: what the outputs must show in the current cycle.
  bit            m_clearing;
  int            m_ck;        // cycles spent in the current clear
  bit            m_prio_aux;
  bit            m_gp, m_ga;  // grants expected in the cycle just checked
  bit            e_we, e_done, e_busy, e_oob;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  // DUT values sampled at the last checked negedge.
  logic          s_pr, s_ar, s_we, s_done, s_busy, s_oob;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_clearing = 1'b1;
    m_ck       = 0;
    m_prio_aux = 1'b0;
    e_we = 1'b0; e_done = 1'b0; e_busy = 1'b0; e_oob = 1'b0;
    e_addr = '0; e_data = '0;
  endtask

  // One cycle: check at negedge, advance model across the next posedge.
  task automatic step();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    s_pr = paint_ready; s_ar = aux_ready; s_we = mem_we;
    s_addr = mem_addr; s_data = mem_data;
    s_done = clear_done; s_busy = clear_busy; s_oob = oob_err;

    m_gp = 1'b0; m_ga = 1'b0;
    if (!m_clearing && !clear_req) begin
      if (paint_valid && aux_valid) begin
        if (m_prio_aux) m_ga = 1'b1; else m_gp = 1'b1;
      end else if (paint_valid) begin
        m_gp = 1'b1;
      end else if (aux_valid) begin
        m_ga = 1'b1;
      end
    end

    chk("paint_ready", s_pr, m_gp);
    chk("aux_ready", s_ar, m_ga);
    chk("mem_we", s_we, e_we);
    if (e_we) begin
      chk("mem_addr", s_addr, e_addr);
      chk("mem_data", s_data, e_data);
    end
    chk("clear_done", s_done, e_done);
    chk("clear_busy", s_busy, e_busy);
    chk("oob_err", s_oob, e_oob);

    if (m_clearing) begin
      if (m_ck < NP) begin
        e_we = 1'b1; e_addr = AW'(m_ck); e_data = CC;
        e_busy = 1'b1; e_done = 1'b0;
        m_ck++;
      end else begin
        m_clearing = 1'b0;
        e_we = 1'b0; e_busy = 1'b0; e_done = 1'b1;
      end
    end else if (clear_req) begin
      m_clearing = 1'b1; m_ck = 0;
      e_we = 1'b0; e_busy = 1'b1; e_done = 1'b0;
    end else begin
      e_done = 1'b0;
      e_we   = 1'b0;
      if (m_gp || m_ga) begin
        a = m_ga ? aux_addr : paint_addr;
        d = m_ga ? aux_data : paint_data;
        if (a < NP) begin
          e_we = 1'b1; e_addr = a; e_data = d;
        end else begin
          e_oob = 1'b1;
        end
        m_prio_aux = m_gp;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();

    // Clear after reset release.
    step();
    chk("t1_first_we", s_we, 0);
    chk("t1_first_busy", s_busy, 0);
    for (int i = 0; i < NP; i++) begin
      step();
      chk("t1_we", s_we, 1);
      chk("t1_addr", s_addr, i);
      chk("t1_data", s_data, 9'h1FF);
    end
    step();
    chk("t1_done", s_done, 1);
    chk("t1_busy_low", s_busy, 0);
    chk("t1_we_low", s_we, 0);
    step();
    chk("t1_done_once", s_done, 0);

    // Both requesters held: P, A, P, A.
    paint_valid = 1'b1; paint_addr = 3; paint_data = 9'h007;
    aux_valid   = 1'b1; aux_addr   = 4; aux_data   = 9'h038;
    step(); chk("t3_g0_p", s_pr, 1); chk("t3_g0_a", s_ar, 0);
    step(); chk("t3_g1_a", s_ar, 1); chk("t3_w0", s_addr, 3);
    step(); chk("t3_g2_p", s_pr, 1); chk("t3_w1", s_addr, 4);
    step(); chk("t3_g3_a", s_ar, 1); chk("t3_w2", s_addr, 3);
    paint_valid = 1'b0; aux_valid = 1'b0;
    step(); chk("t3_w3", s_addr, 4); chk("t3_w3_data", s_data, 9'h038);
    step(); chk("t3_idle", s_we, 0);

    // Single paint request.
    paint_valid = 1'b1; paint_addr = 5; paint_data = 9'h1C0;
    step(); chk("t2_ready", s_pr, 1);
    paint_valid = 1'b0;
    step();
    chk("t2_we", s_we, 1); chk("t2_addr", s_addr, 5); chk("t2_data", s_data, 9'h1C0);

    // Out-of-range aux request.
    aux_valid = 1'b1; aux_addr = 16; aux_data = 9'h0AA;
    step(); chk("t5_ready", s_ar, 1);
    aux_valid = 1'b0;
    step(); chk("t5_no_we", s_we, 0); chk("t5_oob", s_oob, 1);
    repeat (3) step();
    chk("t5_oob_sticky", s_oob, 1);

    // Clear request beats both valids; valids wait out the clear.
    paint_valid = 1'b1; paint_addr = 7; paint_data = 9'h011;
    aux_valid   = 1'b1; aux_addr   = 8; aux_data   = 9'h022;
    clear_req = 1'b1;
    step(); chk("t4_no_p", s_pr, 0); chk("t4_no_a", s_ar, 0);
    clear_req = 1'b0;
    step(); chk("t4_entry_we", s_we, 0); chk("t4_entry_busy", s_busy, 1);
    for (int i = 0; i < NP; i++) begin
      step();
      chk("t4_blk_p", s_pr, 0); chk("t4_blk_a", s_ar, 0);
      chk("t4_addr", s_addr, i);
    end
    step(); chk("t4_done", s_done, 1); chk("t4_served_p", s_pr, 1);
    step(); chk("t4_served_a", s_ar, 1); chk("t4_w_p", s_addr, 7);
    paint_valid = 1'b0; aux_valid = 1'b0;
    step(); chk("t4_w_a", s_addr, 8); chk("t4_w_a_data", s_data, 9'h022);

    // Randomized traffic with legal handshakes.
    for (int n = 0; n < 1500; n++) begin
      if (paint_valid && !m_gp) begin
        if ($urandom_range(0, 9) == 0) paint_valid = 1'b0;
      end else begin
        paint_valid = ($urandom_range(0, 2) != 0);
        paint_addr  = AW'($urandom_range(0, 19));
        paint_data  = DW'($urandom);
      end
      if (aux_valid && !m_ga) begin
        if ($urandom_range(0, 9) == 0) aux_valid = 1'b0;
      end else begin
        aux_valid = ($urandom_range(0, 2) != 0);
        aux_addr  = AW'($urandom_range(0, 19));
        aux_data  = DW'($urandom);
      end
      clear_req = ($urandom_range(0, 59) == 0);
      step();
    end

    // Reset in the middle of a clear.
    paint_valid = 1'b0; aux_valid = 1'b0; clear_req = 1'b0;
    for (int k = 0; k < 40 && m_clearing; k++) step();
    step();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    repeat (8) step();
    chk("t6_pre_addr", mem_addr, 7);
    chk("t6_pre_we", mem_we, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_data", mem_data, 0);
    chk("t6_rst_busy", clear_busy, 0);
    chk("t6_rst_done", clear_done, 0);
    chk("t6_rst_oob", oob_err, 0);
    #2;
    reset = 1'b0;
    model_reset();
    step();
    chk("t6_idle_we", s_we, 0);
    step();
    chk("t6_restart_we", s_we, 1);
    chk("t6_restart_addr", s_addr, 0);
    repeat (NP + 2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
